ql_cfg_chain_loader: RTL and testbench

//   Sequencer that loads a serial configuration chain built from DFFE cells
//   (chain D fed by sdo, all E pins driven by sen, one shared QCK).

---
 rtl/ql_cfg_chain_loader_if.sv | 19 +
 rtl/ql_cfg_chain_loader.sv | 126 ++++++++++++
 tb/tb_ql_cfg_chain_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ql_cfg_chain_loader_if.sv
// Word-stream interface between a configuration source and the chain loader.
// The source side (master) drives din/din_valid and samples din_ready.
// With QL_CFG_PARITY_EN defined, each word also carries an even-parity bit.
interface ql_cfg_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
`ifdef QL_CFG_PARITY_EN
    logic              din_par;

    modport master (output din, output din_valid, output din_par, input din_ready);
    modport slave  (input din, input din_valid, input din_par, output din_ready);
`else
    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
`endif
endinterface

// File: rtl/ql_cfg_chain_loader.sv
// ql_cfg_chain_loader: loads a serial DFFE configuration chain.
// Words arrive over a valid/ready stream and are shifted out LSB first on sdo
// with sen asserted for exactly CHAIN_LEN cycles, followed by a one-cycle done.
// The final word is truncated when CHAIN_LEN is not a multiple of WORD_W.
// Optional feature macro: QL_CFG_PARITY_EN adds an even-parity check on each
// word; a bad word aborts the load and sets the sticky err flag.
module ql_cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic                          QCK,
    input  logic                          R,
    input  logic                          start,
    ql_cfg_chain_loader_if.slave          src,
    output logic                          sdo,
    output logic                          sen,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int NB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [BL_W-1:0]   bits_left;
    logic [NB_W-1:0]   nbits;
    logic              sen_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              par_bad;

    // Parity check of the presented word; constant 0 when the option is absent.
`ifdef QL_CFG_PARITY_EN
    assign par_bad = ^{src.din, src.din_par};
`else
    assign par_bad = 1'b0;
`endif

    // Sequencer: state, shift datapath and all registered control outputs.
    // NOTE: every register here uses <= so all of them update together from
    // the values present before the edge; mixing in = would create ordering
    // dependencies inside the block.
    always_ff @(posedge QCK) begin
        // NOTE: the shift register and counters are cleared on reset as well,
        // so a load aborted mid-shift leaves no stale data behind.
        if (R) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bits_left <= '0;
            nbits     <= '0;
            sen_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT;
                        bits_left <= BL_W'(CHAIN_LEN);
                        err_q     <= 1'b0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (src.din_valid) begin
                        ready_q <= 1'b0;
                        if (par_bad) begin
                            // Corrupt word: drop it and abandon the load.
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            shreg <= src.din;
                            nbits <= (32'(bits_left) >= WORD_W) ? NB_W'(WORD_W)
                                                                : NB_W'(bits_left);
                            sen_q <= 1'b1;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg     <= shreg >> 1;
                    bits_left <= bits_left - BL_W'(1);
                    nbits     <= nbits - NB_W'(1);
                    if (nbits == NB_W'(1)) begin
                        sen_q <= 1'b0;
                        if (bits_left == BL_W'(1)) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign src.din_ready = ready_q;
    assign sen           = sen_q;
    assign sdo           = sen_q & shreg[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ql_cfg_chain_loader.sv
// Testbench for ql_cfg_chain_loader: two instances (CHAIN_LEN 16 and 12,
// WORD_W 8) driven by directed and randomised loads. The expected bit stream
// is built from the word list, LSB first, cut to CHAIN_LEN bits.
module tb_ql_cfg_chain_loader;
    logic       QCK = 1'b0;
    logic       R;
    logic       start   [2];
    logic [7:0] din_d   [2];
    logic       val     [2];
    logic       par     [2];
    logic       sdo     [2];
    logic       sen     [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];
    logic       rdy     [2];
    int         len_of  [2];

    int n_checks = 0;
    int n_err    = 0;

    // Monitor results
    bit obs_bits[$];
    int done_cnt;
    int done_at;
    int idle_bad;

    always #5 QCK = ~QCK;

    ql_cfg_chain_loader_if #(.WORD_W(8)) if0 ();
    ql_cfg_chain_loader_if #(.WORD_W(8)) if1 ();

    assign if0.din       = din_d[0];
    assign if0.din_valid = val[0];
    assign rdy[0]        = if0.din_ready;
    assign if1.din       = din_d[1];
    assign if1.din_valid = val[1];
    assign rdy[1]        = if1.din_ready;
`ifdef QL_CFG_PARITY_EN
    assign if0.din_par   = par[0];
    assign if1.din_par   = par[1];
`endif

    ql_cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut16 (
        .QCK(QCK), .R(R), .start(start[0]), .src(if0.slave),
        .sdo(sdo[0]), .sen(sen[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    ql_cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut12 (
        .QCK(QCK), .R(R), .start(start[1]), .src(if1.slave),
        .sdo(sdo[1]), .sen(sen[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Chain observer: collect every bit shifted with sen high, count done
    // pulses and flag any nonzero sdo while sen is low.
    always @(negedge QCK) begin
        for (int k = 0; k < 2; k++) begin
            if (sen[k] === 1'b1) obs_bits.push_back(sdo[k]);
            else if (sdo[k] !== 1'b0) idle_bad++;
            if (done[k] === 1'b1) begin
                done_cnt++;
                done_at = obs_bits.size();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic wait_ready(input int s, output bit ok);
        int n = 0;
        while (rdy[s] !== 1'b1 && n < 64) begin
            @(negedge QCK);
            n++;
        end
        ok = (rdy[s] === 1'b1);
        if (!ok) chk("ready_timeout", 32'(rdy[s]), 32'd1);
    endtask

    task automatic clear_mon();
        obs_bits.delete();
        done_cnt = 0;
        done_at  = -1;
        idle_bad = 0;
    endtask

    // One complete load on instance s. gap_idx selects a word before which
    // din_valid stays low for gap_len cycles in WAIT; poke holds start high
    // for the whole load.
    task automatic do_load(input int s, input logic [7:0] words[$],
                           input int gap_idx, input int gap_len, input bit poke);
        bit exp[$];
        bit ok;
        int n;
        logic [7:0] w;
        int len = len_of[s];
        clear_mon();
        @(negedge QCK); start[s] = 1'b1;
        @(negedge QCK); start[s] = poke;
        chk("busy_after_start", 32'(busy[s]), 32'd1);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            if (i == gap_idx) begin
                val[s] = 1'b0;
                wait_ready(s, ok);
                if (!ok) begin start[s] = 1'b0; return; end
                repeat (gap_len) begin
                    @(negedge QCK);
                    chk("gap_sen", 32'(sen[s]), 32'd0);
                    chk("gap_sdo", 32'(sdo[s]), 32'd0);
                    chk("gap_ready", 32'(rdy[s]), 32'd1);
                end
            end
            din_d[s] = w;
            par[s]   = ^w;
            val[s]   = 1'b1;
            wait_ready(s, ok);
            if (!ok) begin start[s] = 1'b0; val[s] = 1'b0; return; end
            @(posedge QCK);
            @(negedge QCK);
        end
        val[s]   = 1'b0;
        start[s] = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge QCK);
            n++;
        end
        @(negedge QCK);
        chk("busy_after_done", 32'(busy[s]), 32'd0);
        foreach (words[i])
            for (int b = 0; b < 8; b++)
                if (exp.size() < len) exp.push_back(words[i][b]);
        chk("sen_cycles", 32'(obs_bits.size()), 32'(len));
        for (int j = 0; j < len && j < obs_bits.size(); j++)
            chk($sformatf("bit%0d", j), 32'(obs_bits[j]), 32'(exp[j]));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_pos", 32'(done_at), 32'(len));
        chk("idle_sdo", 32'(idle_bad), 32'd0);
    endtask

    initial begin
        logic [7:0] wq[$];
        bit ok;
        int n;
        int s;
        len_of[0] = 16;
        len_of[1] = 12;
        R = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; din_d[k] = '0; val[k] = 1'b0; par[k] = 1'b0;
        end
        repeat (3) @(negedge QCK);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(rdy[k]), 32'd0);
            chk("rst_sen",   32'(sen[k]), 32'd0);
            chk("rst_sdo",   32'(sdo[k]), 32'd0);
            chk("rst_busy",  32'(busy[k]), 32'd0);
            chk("rst_done",  32'(done[k]), 32'd0);
            chk("rst_err",   32'(err[k]), 32'd0);
        end
        R = 1'b0;

        // Two words back to back on a 16-bit chain
        wq = {8'hA5, 8'h3C};
        do_load(0, wq, -1, 0, 1'b0);

        // 12-bit chain: second word only contributes its low nibble
        wq = {8'hFF, 8'h0F};
        do_load(1, wq, -1, 0, 1'b0);

        // Five idle WAIT cycles before the second word
        wq = {8'($urandom), 8'($urandom)};
        do_load(0, wq, 1, 5, 1'b0);

        // Reset during the third shift cycle, then a fresh full load
        clear_mon();
        @(negedge QCK); start[0] = 1'b1;
        @(negedge QCK); start[0] = 1'b0;
        din_d[0] = 8'($urandom); par[0] = ^din_d[0]; val[0] = 1'b1;
        wait_ready(0, ok);
        @(posedge QCK);
        @(negedge QCK);
        val[0] = 1'b0;
        n = 0;
        while (obs_bits.size() < 3 && n < 20) begin
            @(negedge QCK);
            n++;
        end
        R = 1'b1;
        @(negedge QCK);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd0);
        chk("mid_rst_sen",   32'(sen[0]), 32'd0);
        chk("mid_rst_sdo",   32'(sdo[0]), 32'd0);
        chk("mid_rst_busy",  32'(busy[0]), 32'd0);
        chk("mid_rst_done",  32'(done[0]), 32'd0);
        R = 1'b0;
        wq = {8'h5A, 8'hC3};
        do_load(0, wq, -1, 0, 1'b0);

        // start held high throughout a load is ignored
        wq = {8'($urandom), 8'($urandom)};
        do_load(1, wq, -1, 0, 1'b1);

        // Randomised loads on both chain lengths
        for (int it = 0; it < 8; it++) begin
            s = int'($urandom_range(1, 0));
            wq.delete();
            for (int i = 0; i < (len_of[s] + 7) / 8; i++) wq.push_back(8'($urandom));
            if ($urandom_range(1, 0) == 1)
                do_load(s, wq, int'($urandom_range(1, 0)), int'($urandom_range(4, 1)), 1'b0);
            else
                do_load(s, wq, -1, 0, 1'b0);
        end

`ifdef QL_CFG_PARITY_EN
        // Bad parity: word dropped, err sticky, next start clears it
        clear_mon();
        @(negedge QCK); start[0] = 1'b1;
        @(negedge QCK); start[0] = 1'b0;
        din_d[0] = 8'h01; par[0] = 1'b0; val[0] = 1'b1;
        @(posedge QCK);
        @(negedge QCK);
        val[0] = 1'b0;
        chk("par_err",  32'(err[0]), 32'd1);
        chk("par_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(negedge QCK);
        chk("par_err_hold", 32'(err[0]), 32'd1);
        chk("par_no_sen",   32'(obs_bits.size()), 32'd0);
        chk("par_no_done",  32'(done_cnt), 32'd0);
        @(negedge QCK); start[0] = 1'b1;
        @(negedge QCK); start[0] = 1'b0;
        chk("par_err_clr", 32'(err[0]), 32'd0);
        chk("par_restart_busy", 32'(busy[0]), 32'd1);
        R = 1'b1;
        @(negedge QCK);
        R = 1'b0;
`endif

        repeat (2) @(negedge QCK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
